// File: rtl/arm_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state
// encodings, the bubble instruction word and the datapath word width.
package arm_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // One fetched word waiting for decode: pc is already PC+PC_STEP.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_word_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory read port: the fetch stage is the master, the memory
// answers with imem_ack/imem_rdata after a variable latency.
interface instruction_fetch_stage_if;
  import arm_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush wins over load and turns the slot into a
// bubble; pc is left alone on flush because a bubble's pc is meaningless.
module if_id_reg
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instr,
  input  logic              valid,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_instr,
  output logic              if_valid
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc    <= '0;
      if_instr <= BUBBLE_INSTR;
      if_valid <= 1'b0;
    end else if (flush) begin
      if_instr <= BUBBLE_INSTR;
      if_valid <= 1'b0;
    end else if (load) begin
      if_pc    <= pc;
      if_instr <= instr;
      if_valid <= valid;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM (S_REQ/S_HOLD/S_DROP) and a one-entry
// hold buffer feeding if_id_reg. Define IF_PERF_CNT_EN to add fetch/stall counters.
module instruction_fetch_stage
  import arm_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                PC_STEP  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      branch_taken,
  input  logic [WORD_W-1:0]         branch_address,
  instruction_fetch_stage_if.master imem,
  output logic [WORD_W-1:0]         pc_out,
  output logic [WORD_W-1:0]         instruction,
  output logic                      valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0]         fetch_count,
  output logic [WORD_W-1:0]         stall_count
`endif
);

  localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

  fetch_state_e      state, state_next;
  logic [WORD_W-1:0] pc, pc_next, pc_inc;
  fetch_word_t       hold, hold_next;

  logic              ld, fl, ld_valid;
  logic [WORD_W-1:0] ld_pc, ld_instr;

  // Natural 32-bit wrap gives the modulo PC arithmetic for free.
  assign pc_inc         = pc + STEP;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      // NOTE: the hold buffer is a single register, not an array, so clearing
      // it on reset costs nothing and keeps stale words out of IF/ID.
      hold  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      hold  <= hold_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_next    = state;
    pc_next       = pc;
    hold_next     = hold;
    imem.imem_req = 1'b0;
    ld            = 1'b0;
    fl            = 1'b0;
    ld_pc         = pc_out;
    ld_instr      = BUBBLE_INSTR;
    ld_valid      = 1'b0;

    case (state)
      S_REQ: begin
        imem.imem_req = 1'b1;
        if (branch_taken) begin
          pc_next    = branch_address;
          fl         = 1'b1;
          hold_next  = '0;
          // Without an ack the old request is still in flight and its answer
          // must be swallowed before a new request can go out.
          state_next = imem.imem_ack ? S_REQ : S_DROP;
        end else if (imem.imem_ack) begin
          pc_next = pc_inc;
          if (freeze) begin
            hold_next.pc    = pc_inc;
            hold_next.instr = imem.imem_rdata;
            state_next      = S_HOLD;
          end else begin
            ld       = 1'b1;
            ld_pc    = pc_inc;
            ld_instr = imem.imem_rdata;
            ld_valid = 1'b1;
          end
        end else if (!freeze) begin
          ld = 1'b1;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          pc_next    = branch_address;
          fl         = 1'b1;
          hold_next  = '0;
          state_next = S_REQ;
        end else if (!freeze) begin
          ld         = 1'b1;
          ld_pc      = hold.pc;
          ld_instr   = hold.instr;
          ld_valid   = 1'b1;
          hold_next  = '0;
          state_next = S_REQ;
        end
      end

      S_DROP: begin
        if (branch_taken) begin
          pc_next   = branch_address;
          fl        = 1'b1;
          hold_next = '0;
        end
        if (imem.imem_ack) begin
          state_next = S_REQ;
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .flush    (fl),
    .pc       (ld_pc),
    .instr    (ld_instr),
    .valid    (ld_valid),
    .if_pc    (pc_out),
    .if_instr (instruction),
    .if_valid (valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ld && ld_valid) begin
        fetch_count <= fetch_count + 1'b1;
      end
      if (freeze) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: behavioural memory, a
// program-order reference model and a scoreboard checked by a separate monitor.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] STEP     = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  instruction_fetch_stage_if imem_bus ();

  instruction_fetch_stage #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem           (imem_bus),
    .pc_out         (pc_out),
    .instruction    (instruction),
    .valid          (valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: instructions fetched but not yet shown to decode, the
  // next program-order fetch address, and the memory's outstanding request.
  exp_t        sb_q[$];
  logic [31:0] model_pc;
  logic [31:0] pend_addr;
  bit          pending;
  bit          stale;
  bit          in_hold;
  bit          exp_valid;
  bit          exp_zero;
  int          wait_cnt;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) begin
      return 32'hFFFF_FFF8;
    end
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  // One clock of stimulus: memory answers, control inputs, model update for
  // the coming rising edge. lat < 0 picks a random wait for a new request.
  task automatic step(input bit frz, input bit br, input logic [31:0] tgt, input int lat);
    bit ack;
    bit kept;
    @(negedge clk);
    check("imem_req", 32'(imem_bus.imem_req), 32'(!in_hold && !(pending && stale)));
    if (!pending && imem_bus.imem_req === 1'b1) begin
      check("imem_addr", imem_bus.imem_addr, model_pc);
      pending   = 1'b1;
      stale     = 1'b0;
      pend_addr = imem_bus.imem_addr;
      wait_cnt  = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    end else if (pending && !stale && imem_bus.imem_req === 1'b1) begin
      check("addr_stable", imem_bus.imem_addr, pend_addr);
    end

    ack = pending && (wait_cnt == 0);
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = ack ? word_of(pend_addr) : $urandom;
    if (pending && wait_cnt > 0) wait_cnt--;

    freeze         = frz;
    branch_taken   = br;
    branch_address = br ? tgt : $urandom;

    kept = ack && !stale && !br;
    if (ack) pending = 1'b0;
    if (frz) exp_stall = exp_stall + 1;

    if (br) begin
      sb_q.delete();
      model_pc  = tgt;
      in_hold   = 1'b0;
      if (pending) stale = 1'b1;
      exp_valid = 1'b0;
      exp_zero  = 1'b1;
    end else begin
      if (kept) begin
        sb_q.push_back('{pc: model_pc + STEP, instr: word_of(model_pc)});
        model_pc = model_pc + STEP;
      end
      if (!frz) begin
        exp_valid = kept || in_hold;
        if (kept || in_hold) exp_zero = 1'b0;
        in_hold = 1'b0;
      end else if (kept) begin
        in_hold = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst                 = 1'b0;
    freeze              = 1'b0;
    branch_taken        = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    sb_q.delete();
    model_pc  = RESET_PC;
    pending   = 1'b0;
    stale     = 1'b0;
    in_hold   = 1'b0;
    exp_valid = 1'b0;
    exp_zero  = 1'b1;
    exp_fetch = '0;
    exp_stall = '0;
    #1;
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_count", fetch_count, 32'h0);
    check("rst_stall_count", stall_count, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: after each rising edge, compare what decode sees.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b1) begin
        check("valid", 32'(valid), 32'(exp_valid));
        if (exp_zero) check("flush_instr", instruction, 32'h0);
        if (valid === 1'b1 && freeze === 1'b0 && branch_taken === 1'b0) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            exp_fetch = exp_fetch + 1;
            check("pc_out", pc_out, e.pc);
            check("instruction", instruction, e.instr);
          end
        end
`ifdef IF_PERF_CNT_EN
        check("fetch_count", fetch_count, exp_fetch);
        check("stall_count", stall_count, exp_stall);
`endif
      end
    end
  end

  initial begin
    rst                 = 1'b0;
    freeze              = 1'b0;
    branch_taken        = 1'b0;
    branch_address      = '0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    do_reset();

    // Back-to-back fetches, then a freeze landing on the ack of address 8.
    step(1'b0, 1'b0, '0, 0);
    step(1'b0, 1'b0, '0, 0);
    step(1'b1, 1'b0, '0, 0);
    step(1'b1, 1'b0, '0, 0);
    step(1'b1, 1'b0, '0, 0);
    step(1'b0, 1'b0, '0, 0);
    step(1'b0, 1'b0, '0, 0);
    // Branch to 0x100 while the request at 0x10 waits two more cycles.
    step(1'b0, 1'b1, 32'h0000_0100, 2);
    step(1'b0, 1'b0, '0, 0);
    step(1'b0, 1'b0, '0, 0);
    step(1'b0, 1'b0, '0, 0);
    // Branch with freeze on the same cycle, coincident with an ack, to the
    // last word of the address space; the next fetch wraps to 0.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 0);
    step(1'b0, 1'b0, '0, 0);
    step(1'b0, 1'b0, '0, 0);
    // Park in S_HOLD, then reset asynchronously.
    step(1'b1, 1'b0, '0, 0);
    step(1'b1, 1'b0, '0, 0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, rand_target(), -1);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, -1);
    end
    @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
